// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_e     : frame deframer state encoding
//   - PS2_PFX_EXT/BRK : scan-code prefix bytes (extended / break)
//   - PS2_FRAME_BITS  : start + 8 data + parity + stop
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK    = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line front end and frame deframer.
//   Synchronizes the raw ps2_clk/ps2_data lines, glitch-filters the clock,
//   deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
//   aborts a frame that stalls for TIMEOUT_CYCLES clk cycles.
// Ports:
//   i_clk, i_rst      : system clock, synchronous active-high reset
//   i_ps2_clk/data    : raw asynchronous PS/2 lines
//   o_rx_byte         : last good frame byte (holds)
//   o_rx_valid        : one-cycle strobe, o_rx_byte updated
//   o_rx_err          : one-cycle strobe, frame discarded
//   o_busy            : frame FSM outside IDLE
//   o_good_pre        : good frame completes this cycle (o_rx_valid next cycle)
//   o_err_pre         : frame discarded this cycle (o_rx_err next cycle)
//   o_byte_pre        : byte that o_rx_byte takes when o_good_pre is high
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILT_LEN       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_err,
  output logic       o_busy,
  output logic       o_good_pre,
  output logic       o_err_pre,
  output logic [7:0] o_byte_pre
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronizers
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // Glitch filter: the filtered clock flips only after FILT_LEN consecutive
  // synchronized samples that disagree with it.
  logic           r_clk_filt;
  logic           r_clk_prev;
  logic [FCW-1:0] r_filt_cnt;
  logic           w_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_filt <= 1'b1;
      r_clk_prev <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_prev <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILT_LEN - 1)) begin
        r_clk_filt <= ~r_clk_filt;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_filt;

  // Frame FSM
  ps2_state_e     r_state, w_state_nxt;
  logic [2:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_parity, w_parity_nxt;
  logic [TOW-1:0] r_to_cnt;
  logic           w_to_hit;
  logic           w_good;
  logic           w_bad;
  logic           w_par_ok;

  assign w_to_hit = (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
  assign w_par_ok = ^{r_shift, r_parity};

  // A fall in the terminal-count cycle is handled as a normal bit: the fall
  // branches are tested before the timeout branches.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_good        = 1'b0;
    w_bad         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_dat_s) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_shift_nxt   = {w_dat_s, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end
        end else if (w_to_hit) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (w_fall) begin
          w_parity_nxt = w_dat_s;
          w_state_nxt  = ST_STOP;
        end else if (w_to_hit) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          if (w_dat_s && w_par_ok) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end else if (w_to_hit) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
    end
  end

  // Timeout counter: idle-cleared, restarted by every fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (w_fall || (r_state == ST_IDLE)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TOW'(1);
    end
  end

  // Registered frame outputs
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;
  logic       r_rx_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= w_good;
      r_rx_err   <= w_bad;
      if (w_good) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  assign o_rx_byte  = r_rx_byte;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_err   = r_rx_err;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_good_pre = w_good;
  assign o_err_pre  = w_bad;
  assign o_byte_pre = r_shift;

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver top.
//   Frame reception is done by ps2_frame_rx; this level folds the E0
//   (extended) and F0 (break) prefixes into one key event per key action.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   rx_byte/rx_valid    : last good frame byte and its update strobe
//   rx_err              : strobe, frame discarded (parity/stop/timeout)
//   key_code/ext/break  : last key event (hold)
//   key_valid           : strobe, key event fields updated
//   busy                : frame in progress
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILT_LEN       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       busy
);

  logic       w_good_pre;
  logic       w_err_pre;
  logic [7:0] w_byte_pre;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILT_LEN      (FILT_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_rx_byte (rx_byte),
    .o_rx_valid(rx_valid),
    .o_rx_err  (rx_err),
    .o_busy    (busy),
    .o_good_pre(w_good_pre),
    .o_err_pre (w_err_pre),
    .o_byte_pre(w_byte_pre)
  );

  // The tracker acts on the pre-register strobes so key_valid lands in the
  // same cycle as the rx_valid carrying the code byte.
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_break;
  logic       r_key_valid;
  logic       r_ext_pend;
  logic       r_brk_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_key_valid <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_err_pre) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_good_pre) begin
        if (w_byte_pre == PS2_PFX_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte_pre == PS2_PFX_BRK) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_key_valid <= 1'b1;
          r_key_code  <= w_byte_pre;
          r_key_ext   <= r_ext_pend;
          r_key_break <= r_brk_pend;
          r_ext_pend  <= 1'b0;
          r_brk_pend  <= 1'b0;
        end
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_break = r_key_break;
  assign key_valid = r_key_valid;

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
Front-end keyboard receiver. Samples the raw PS/2 clock/data lines in the system clock domain, deframes 11-bit PS/2 frames and checks them. Folds the E0 (extended) and F0 (break) prefix bytes into one key event per key action. Sits directly upstream of the scan-code-to-ASCII converter and the UART/7-segment path, and supplies the key-done strobe they consume.

Parameters:
SYNC_STAGES, 2, flops in each ps2_clk/ps2_data synchronizer chain (min 2)
FILT_LEN, 4, consecutive equal synchronized ps2_clk samples required before the filtered clock changes
TIMEOUT_CYCLES, 100000, clk cycles with no falling edge mid-frame before the frame is aborted (2 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from connector (asynchronous)
ps2_data  input  1  raw PS/2 data from connector (asynchronous)
rx_byte  output  8  last correctly received frame byte; holds until the next good frame
rx_valid  output  1  one-cycle strobe: rx_byte updated
rx_err  output  1  one-cycle strobe: frame discarded (parity, stop or timeout)
key_code  output  8  scan code of last key event; holds
key_ext  output  1  last key event was E0-prefixed; holds
key_break  output  1  last key event was a release (F0-prefixed); holds
key_valid  output  1  one-cycle strobe: key_code/key_ext/key_break updated
busy  output  1  high while the frame FSM is outside IDLE

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, bit count/shift/timeout/pending flags cleared, synchronizer and filter state set to 1. A reset mid-frame discards the partial frame.
- Sync/filter: both lines pass through SYNC_STAGES flops. Filtered clock toggles only after FILT_LEN equal consecutive samples differing from its current value.
- fall = one-cycle strobe on a 1->0 transition of the filtered clock. Data is sampled from the synchronized ps2_data in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE and raise no error.
  - DATA: on each fall, shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Good frame: rx_byte/rx_valid. Bad frame: rx_err. Either way, return to IDLE.
- Latency: rx_valid/rx_err are high exactly one cycle after the stop-bit fall cycle. key_valid is high in the same cycle as the rx_valid that carries the code byte.
- Timeout: the counter clears on every fall and in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 causes one rx_err pulse and a return to IDLE. If a fall and the terminal count occur in the same cycle, the fall wins.
- Key tracker, on rx_valid:
  - byte E0: ext_pend=1, no key_valid.
  - byte F0: brk_pend=1, no key_valid.
  - any other byte: key_valid=1, key_code=byte, key_ext=ext_pend, key_break=brk_pend, then both pending flags clear.
- rx_err clears ext_pend and brk_pend.
- rx_valid and rx_err are never high together. busy falls in the same cycle as rx_valid/rx_err.

Decomposition:
- Shared package ps2_pkg holds:
  - the frame state encoding (IDLE/DATA/PARITY/STOP)
  - PS2_PFX_EXT = 8'hE0, PS2_PFX_BRK = 8'hF0
  - the frame length constant 11
- One natural sub-module, ps2_frame_rx, containing synchronizers, glitch filter, frame FSM and timeout. It outputs rx_byte/rx_valid/rx_err/busy.
- The prefix tracker stays in ps2_key_rx.

Test Plan:
- Frame 0x1C (parity 0, stop 1), PS/2 clock ~12.5 kHz -> one rx_valid, rx_byte=0x1C; one key_valid with key_code=0x1C, key_ext=0, key_break=0.
- Frames F0,1C -> two rx_valid, one key_valid: key_code=0x1C, key_break=1, key_ext=0.
- Frames E0,F0,75 -> three rx_valid, one key_valid: key_code=0x75, key_ext=1, key_break=1. A following 1C gives key_ext=0, key_break=0.
- Frame 0x1C with parity=1 -> rx_err pulse, no rx_valid/key_valid, rx_byte unchanged. Next good frame 0x32 decodes normally.
- Start plus 4 data bits then ps2_clk held high -> rx_err exactly TIMEOUT_CYCLES cycles after the last fall, busy=0. Subsequent 0x1C decodes correctly.
- Glitches and reset:
  - 2-cycle low glitch on ps2_clk in IDLE (FILT_LEN=4) -> no state change, busy stays 0.
  - rst asserted mid-DATA -> all outputs 0 next cycle; the next full frame decodes.
